// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage; quotient to LO, remainder to HI.
// Latency: WIDTH+1 cycles from first start to DONE (1 cycle for divide-by-zero); result held while EX is stalled.
// Backpressure: raises streq_ex_o to hold EX until done; flush_i cancels at once; DONE waits on ex_stall_i.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  output logic             streq_ex_o,
  output logic             res_valid_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr;     // |divisor|
  logic             q_neg;    // negate quotient at the end
  logic             r_neg;    // negate remainder at the end

  logic             opb_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, quo_step, lo_fix, hi_fix;

  // Operand magnitudes and one restoring-division step. The full partial
  // remainder is shifted (WIDTH+1 bits) so unsigned divisors above 2^(WIDTH-1)
  // still divide correctly.
  always_comb begin
    opb_zero = (opb_i == '0);
    abs_a    = (div_signed_i && opa_i[WIDTH-1]) ? (~opa_i + 1'b1) : opa_i;
    abs_b    = (div_signed_i && opb_i[WIDTH-1]) ? (~opb_i + 1'b1) : opb_i;
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ~trial[WIDTH]};
    // Two's-complement negation also yields MIN / -1 = MIN with remainder 0.
    lo_fix   = q_neg ? (~quo_step + 1'b1) : quo_step;
    hi_fix   = r_neg ? (~rem_step + 1'b1) : rem_step;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational stall request and result-valid flag;
  // flush and reset override everything.
  always_comb begin
    state_nxt   = state;
    streq_ex_o  = 1'b0;
    res_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (div_start_i) begin
          streq_ex_o = 1'b1;
          state_nxt  = opb_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        streq_ex_o = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (!ex_stall_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt   = IDLE;
      streq_ex_o  = 1'b0;
      res_valid_o = 1'b0;
    end
    if (rst) begin
      streq_ex_o  = 1'b0;
      res_valid_o = 1'b0;
    end
  end

  // Datapath: operand capture, iteration, and result registers. LO/HI keep
  // their last value outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      lo_o  <= '0;
      hi_o  <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start_i) begin
            if (opb_zero) begin
              lo_o <= '1;
              hi_o <= opa_i;
            end else begin
              quo   <= abs_a;
              dvsr  <= abs_b;
              rem   <= '0;
              cnt   <= '0;
              q_neg <= div_signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
              r_neg <= div_signed_i & opa_i[WIDTH-1];
            end
          end
        end
        BUSY: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            lo_o <= lo_fix;
            hi_o <= hi_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
